// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier for the RISC-V M-extension multiply group.
// One partial-product bit per clock; START/BUSY/DONE handshake with a fixed WIDTH-cycle latency.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       FUNCT,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [1:0]       dbg_state
);

  // Handshake: START is sampled only in IDLE or DONE; BUSY marks the RUN state;
  // DONE is a one-cycle pulse during which RESULT carries the new product.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         state;
  logic [1:0]         funct_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] product;
  logic               last_iter;

  always_comb begin
    a_neg     = OP_A[WIDTH-1] && ((FUNCT == F_MULH) || (FUNCT == F_MULHSU));
    b_neg     = OP_B[WIDTH-1] && (FUNCT == F_MULH);
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    a_mag     = a_neg ? (~OP_A + ONE_W) : OP_A;
    b_mag     = b_neg ? (~OP_B + ONE_W) : OP_B;
    acc_sum   = mplier[0] ? (acc + mcand) : acc;
    product   = neg_q ? (~acc_sum + ONE_2W) : acc_sum;
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      funct_q <= 2'b00;
      neg_q   <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      RESULT  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state   <= S_RUN;
            funct_q <= FUNCT;
            neg_q   <= a_neg ^ b_neg;
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            mplier  <= b_mag;
            acc     <= '0;
            cnt     <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          // The multiplicand shifts left each cycle, equivalent to shifting by the counter.
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            state  <= S_DONE;
            RESULT <= (funct_q == F_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = (state == S_RUN);
  assign DONE      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: drivers push expected results into a queue,
// a negedge monitor pops and compares whenever DONE pulses.
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic             CLK;
  logic             RST_N;
  logic             START;
  logic [1:0]       FUNCT;
  logic [WIDTH-1:0] OP_A;
  logic [WIDTH-1:0] OP_B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic [1:0]       dbg_state;

  logic [WIDTH-1:0] exp_q[$];
  int               checks;
  int               errors;
  int               busy_cnt;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .FUNCT     (FUNCT),
    .OP_A      (OP_A),
    .OP_B      (OP_B),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (!RST_N) begin
      busy_cnt = 0;
    end else begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        check("busy_done_exclusive", {31'b0, BUSY}, 32'd0);
        check("busy_cycles", busy_cnt, WIDTH);
        busy_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", exp_q.size(), 32'd1);
        end else begin
          check("result", RESULT, exp_q.pop_front());
        end
      end
    end
  end

  // Driver: issue one operation and wait (bounded) for its DONE pulse.
  task automatic run_op(input logic [1:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp);
    int n;
    bit seen;
    @(negedge CLK);
    FUNCT = f;
    OP_A  = a;
    OP_B  = b;
    START = 1'b1;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1 START = 1'b0;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 8 && !seen; i++) begin
      @(negedge CLK);
      n++;
      if (DONE) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    else check("latency", n, WIDTH + 1);
  endtask

  initial begin
    int  n;
    bit  seen;
    bit  bad;
    checks   = 0;
    errors   = 0;
    busy_cnt = 0;
    RST_N    = 1'b0;
    START    = 1'b0;
    FUNCT    = 2'b00;
    OP_A     = '0;
    OP_B     = '0;

    repeat (2) @(negedge CLK);
    check("reset_busy", {31'b0, BUSY}, 32'd0);
    check("reset_done", {31'b0, DONE}, 32'd0);
    check("reset_result", RESULT, 32'd0);
    RST_N = 1'b1;

    run_op(2'b00, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB);
    run_op(2'b01, 32'h80000000,   32'h80000000, 32'h40000000);
    run_op(2'b01, 32'hFFFFFFFF,   32'h00000002, 32'hFFFFFFFF);
    run_op(2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'b01, 32'd3,          32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op(2'b11, 32'h00010000,   32'h00010000, 32'h00000001);
    run_op(2'b00, 32'h00010000,   32'h00010000, 32'h00000000);
    run_op(2'b10, 32'h80000000,   32'h00000002, 32'hFFFFFFFF);
    run_op(2'b01, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF);

    // START held high: operands churn during RUN, next op presented in the DONE cycle.
    @(negedge CLK);
    FUNCT = 2'b00;
    OP_A  = 32'h12345678;
    OP_B  = 32'h00000010;
    START = 1'b1;
    exp_q.push_back(32'h23456780);
    for (int k = 0; k < 3; k++) begin
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < WIDTH + 8 && !seen; i++) begin
        @(negedge CLK);
        n++;
        if (DONE) begin
          seen = 1'b1;
        end else begin
          OP_A  = $urandom;
          OP_B  = $urandom;
          FUNCT = 2'($urandom_range(0, 3));
        end
      end
      if (!seen) check("b2b_timeout", 32'd0, 32'd1);
      else check("b2b_spacing", n, WIDTH + 1);
      if (k == 0) begin
        FUNCT = 2'b00;
        OP_A  = 32'h00000000;
        OP_B  = 32'h12345678;
        exp_q.push_back(32'h00000000);
      end else if (k == 1) begin
        FUNCT = 2'b11;
        OP_A  = 32'h80000000;
        OP_B  = 32'h00000004;
        exp_q.push_back(32'h00000002);
      end else begin
        START = 1'b0;
      end
    end

    // Abort a MULHU mid-RUN with an asynchronous reset between edges.
    @(negedge CLK);
    FUNCT = 2'b11;
    OP_A  = 32'hFFFFFFFF;
    OP_B  = 32'hFFFFFFFF;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("async_reset_busy", {31'b0, BUSY}, 32'd0);
    check("async_reset_done", {31'b0, DONE}, 32'd0);
    check("async_reset_result", RESULT, 32'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;

    run_op(2'b00, 32'd5, 32'd6, 32'd30);

    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (RESULT !== 32'd30 || BUSY !== 1'b0 || DONE !== 1'b0) bad = 1'b1;
    end
    check("result_stable", {31'b0, bad}, 32'd0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
